// File: rtl/page_walker_pkg.sv
// page_walker_pkg
// Shared types and constants for the Sv39 page-table walker: FSM state
// encoding, PTE bit positions, page-size encodings and the response
// structure that feeds the TLB refill port.
// No ports (package). Optional feature macro used by this slice:
// PAGE_WALKER_SVNAPOT_EN (64K NAPOT leaf support in pte_decode).
package page_walker_pkg;

  // Width of the physical address driven on the PTE read port.
  localparam int PA_WIDTH = 56;

  // Sv39 PTE field positions.
  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_A       = 6;
  localparam int PTE_D       = 7;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 53;
  localparam int PTE_N       = 63;

  // Page-size encodings returned in page_walk_rsp.pgsize.
  typedef enum logic [1:0] {
    PGSIZE_1G  = 2'd0,
    PGSIZE_2M  = 2'd1,
    PGSIZE_4K  = 2'd2,
    PGSIZE_64K = 2'd3
  } pgsize_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MEM   = 2'd2,
    DONE  = 2'd3
  } walk_state_t;

  typedef struct packed {
    logic [63:0] paddr;
    logic [1:0]  pgsize;
    logic        readable;
    logic        writable;
    logic        executable;
    logic        user;
    logic        dirty;
    logic        fault;
  } page_walk_rsp_t;

endpackage

// File: rtl/page_walker_if.sv
// page_walker_if
// Bundles the walker's request, PTE memory and response signals.
// master : the walker (drives ready, mem_req/mem_addr, response, replace)
// slave  : the TLB/memory side (drives req, req_va, satp_ppn, clear,
//          mem_ack, mem_data)
// Feature macro of this slice: PAGE_WALKER_SVNAPOT_EN (not used here).
interface page_walker_if;
  import page_walker_pkg::*;

  logic                req;
  logic [63:0]         req_va;
  logic [43:0]         satp_ppn;
  logic                clear;
  logic                ready;
  logic                mem_req;
  logic [PA_WIDTH-1:0] mem_addr;
  logic                mem_ack;
  logic [63:0]         mem_data;
  logic                rsp_valid;
  page_walk_rsp_t      page_walk_rsp;
  logic                replace;
  logic [63:0]         replace_va;

  modport master (
    input  req, req_va, satp_ppn, clear, mem_ack, mem_data,
    output ready, mem_req, mem_addr, rsp_valid, page_walk_rsp, replace, replace_va
  );

  modport slave (
    output req, req_va, satp_ppn, clear, mem_ack, mem_data,
    input  ready, mem_req, mem_addr, rsp_valid, page_walk_rsp, replace, replace_va
  );

endinterface

// File: rtl/page_walker_pte_decode.sv
// pte_decode
// Combinational Sv39 PTE classifier.
// Ports:
//   pte      in  64  PTE read from memory
//   level    in  2   walk level the PTE was fetched at (2, 1 or 0)
//   leaf     out 1   PTE is a leaf (R or X set)
//   fault    out 1   PTE terminates the walk with a page fault
//   next_ppn out 44  PPN field, used as the next table base for non-leaves
//   pgsize   out 2   page-size encoding (forced to 4K on fault)
// Macro PAGE_WALKER_SVNAPOT_EN: accept level-0 NAPOT leaves (N=1,
// PPN[3:0]=4'b1000) as 64K pages; without it any N=1 PTE faults.
module pte_decode
  import page_walker_pkg::*;
(
  input  logic [63:0] pte,
  input  logic [1:0]  level,
  output logic        leaf,
  output logic        fault,
  output logic [43:0] next_ppn,
  output logic [1:0]  pgsize
);

  logic        v;
  logic        r;
  logic        w;
  logic        x;
  logic        a;
  logic        n;
  logic [43:0] ppn;
  logic        misaligned;
  logic        unused_bits;

  // Bits the walker never interprets: reserved, RSW, G, and the U/D
  // permission bits which are forwarded by the top directly.
  assign unused_bits = ^{pte[62:54], pte[9:8], pte[PTE_D], pte[5], pte[PTE_U]};

  always_comb begin
    v          = pte[PTE_V];
    r          = pte[PTE_R];
    w          = pte[PTE_W];
    x          = pte[PTE_X];
    a          = pte[PTE_A];
    n          = pte[PTE_N];
    ppn        = pte[PTE_PPN_MSB:PTE_PPN_LSB];
    leaf       = r | x;
    next_ppn   = ppn;
    fault      = 1'b0;
    misaligned = ((level == 2'd2) && (ppn[17:0] != 18'd0)) ||
                 ((level == 2'd1) && (ppn[8:0] != 9'd0));

    case (level)
      2'd2:    pgsize = PGSIZE_1G;
      2'd1:    pgsize = PGSIZE_2M;
      default: pgsize = PGSIZE_4K;
    endcase

    // Invalid or write-without-read encodings fault regardless of level;
    // a pointer at the last level has nowhere left to go.
    if (!v || (!r && w)) begin
      fault = 1'b1;
    end else if (leaf) begin
      if (!a || misaligned) begin
        fault = 1'b1;
      end
    end else if (level == 2'd0) begin
      fault = 1'b1;
    end

`ifdef PAGE_WALKER_SVNAPOT_EN
    if (n) begin
      if (leaf && (level == 2'd0) && (ppn[3:0] == 4'b1000)) begin
        pgsize = PGSIZE_64K;
      end else begin
        fault = 1'b1;
      end
    end
`else
    if (n) begin
      fault = 1'b1;
    end
`endif

    if (fault) begin
      pgsize = PGSIZE_4K;
    end
  end

endmodule

// File: rtl/page_walker.sv
// page_walker
// Sv39 hardware page-table walker servicing one TLB miss at a time.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    page_walker_if.master: req/req_va/satp_ppn/clear/ready request
//          side, mem_req/mem_addr/mem_ack/mem_data PTE read port,
//          rsp_valid/page_walk_rsp/replace/replace_va TLB refill side.
// Macro PAGE_WALKER_SVNAPOT_EN: enables 64K NAPOT leaves (see pte_decode).
module page_walker
  import page_walker_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  page_walker_if.master bus
);

  walk_state_t    state;
  walk_state_t    state_n;
  logic [63:0]    va_q;
  logic [43:0]    ppn_q;
  logic [1:0]     level_q;
  logic [63:0]    pte_q;
  logic           pte_vld_q;
  logic           abort_q;
  page_walk_rsp_t rsp_q;
  page_walk_rsp_t rsp_n;

  logic           accept;
  logic           canonical;
  logic           mem_req;
  logic           ack_take;
  logic           load_rsp;
  logic           walk_next;
  logic           dec_leaf;
  logic           dec_fault;
  logic [43:0]    dec_ppn;
  logic [1:0]     dec_pgsize;
  logic [43:0]    walk_ppn;
  logic [1:0]     walk_level;
  logic [8:0]     walk_vpn;
  logic [55:0]    full_addr;

  // The PTE captured on mem_ack is decoded the following cycle; that
  // cycle either launches the next-level read or finishes the walk.
  pte_decode u_pte_decode (
    .pte      (pte_q),
    .level    (level_q),
    .leaf     (dec_leaf),
    .fault    (dec_fault),
    .next_ppn (dec_ppn),
    .pgsize   (dec_pgsize)
  );

  assign accept    = (state == IDLE) && bus.req && !bus.clear;
  assign canonical = (&va_q[63:38]) || !(|va_q[63:38]);
  assign walk_next = pte_vld_q && !dec_leaf && !dec_fault;
  assign ack_take  = mem_req && bus.mem_ack && !abort_q && !bus.clear;

  // In the decode cycle the next-level address comes straight from the
  // decoder so the read can go out one cycle after the ack; afterwards
  // the registered copies hold it stable until the ack.
  always_comb begin
    walk_ppn   = pte_vld_q ? dec_ppn : ppn_q;
    walk_level = pte_vld_q ? (level_q - 2'd1) : level_q;
    case (walk_level)
      2'd2:    walk_vpn = va_q[38:30];
      2'd1:    walk_vpn = va_q[29:21];
      default: walk_vpn = va_q[20:12];
    endcase
    full_addr = {walk_ppn, walk_vpn, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    mem_req  = 1'b0;
    load_rsp = 1'b0;
    rsp_n    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (bus.clear) begin
          state_n = IDLE;
        end else if (!canonical) begin
          state_n      = DONE;
          load_rsp     = 1'b1;
          rsp_n.pgsize = PGSIZE_4K;
          rsp_n.fault  = 1'b1;
        end else begin
          state_n = MEM;
        end
      end
      MEM: begin
        if (pte_vld_q) begin
          // Decode cycle: nothing is outstanding, so a clear can leave now.
          if (bus.clear) begin
            state_n = IDLE;
          end else if (walk_next) begin
            mem_req = 1'b1;
          end else begin
            state_n          = DONE;
            load_rsp         = 1'b1;
            rsp_n.paddr      = {8'd0, pte_q[PTE_PPN_MSB:PTE_PPN_LSB], 12'd0};
            rsp_n.pgsize     = dec_pgsize;
            rsp_n.readable   = pte_q[PTE_R] & ~dec_fault;
            rsp_n.writable   = pte_q[PTE_W] & ~dec_fault;
            rsp_n.executable = pte_q[PTE_X] & ~dec_fault;
            rsp_n.user       = pte_q[PTE_U] & ~dec_fault;
            rsp_n.dirty      = pte_q[PTE_D] & ~dec_fault;
            rsp_n.fault      = dec_fault;
          end
        end else begin
          // A read is outstanding; an abort only takes effect at its ack.
          mem_req = 1'b1;
          if (bus.mem_ack && (abort_q || bus.clear)) begin
            state_n = IDLE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      va_q      <= '0;
      ppn_q     <= '0;
      level_q   <= '0;
      pte_q     <= '0;
      pte_vld_q <= 1'b0;
      abort_q   <= 1'b0;
      rsp_q     <= '0;
    end else begin
      if (accept) begin
        va_q    <= bus.req_va;
        ppn_q   <= bus.satp_ppn;
        level_q <= 2'd2;
      end else if (walk_next) begin
        ppn_q   <= dec_ppn;
        level_q <= level_q - 2'd1;
      end
      pte_vld_q <= ack_take;
      if (ack_take) begin
        pte_q <= bus.mem_data;
      end
      // The abort flag remembers a clear seen while a read is in flight.
      abort_q <= (state_n != IDLE) && (abort_q || ((state == MEM) && bus.clear));
      if (load_rsp) begin
        rsp_q <= rsp_n;
      end
    end
  end

  assign bus.ready         = (state == IDLE);
  assign bus.mem_req       = mem_req;
  assign bus.mem_addr      = full_addr[PA_WIDTH-1:0];
  assign bus.rsp_valid     = (state == DONE) && !bus.clear;
  assign bus.replace       = bus.rsp_valid && !rsp_q.fault;
  assign bus.page_walk_rsp = rsp_q;
  assign bus.replace_va    = va_q;

endmodule
